// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed seven-segment display driver.
//
// Scans DIGITS digits, one slot of SCAN_DIV clocks per digit. Inside each
// slot the digit is lit while the top BRIGHT_W prescaler bits are below
// `brightness`, which gives PWM dimming and a dark tail that acts as ghosting
// dead time. `value` is copied into a snapshot only at the frame boundary, so
// the displayed frame never tears. All polarities are active-high; the board
// top level does any inversion.
//
// Optional build macro: SEVEN_SEG_DP_EN adds the dp_in port (one decimal point
// per digit, snapshotted together with value). Without it, dp is tied to 0.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   value      4*DIGITS-bit hex word, digit 0 = rightmost nibble
//   blank_lz   1 = blank leading zero digits (digit 0 is never blanked)
//   brightness PWM duty, 0 = dark
//   dp_in      (SEVEN_SEG_DP_EN only) per-digit decimal points
//   an         one-hot digit enable
//   seg        segments {g,f,e,d,c,b,a}
//   dp         decimal point for the current digit
//   frame_tick one-cycle pulse in the first cycle of digit 0's slot
module seven_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEVEN_SEG_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
`endif
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_end, frame_end;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   lz;
  logic                run_zero;
  logic                blanked;
  logic [BRIGHT_W-1:0] phase;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

`ifdef SEVEN_SEG_DP_EN
  logic [DIGITS-1:0] dp_snap_q, dp_snap_d;
`endif

  // Scan counters and frame snapshot.
  always_comb begin
    slot_end  = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
    // SCAN_DIV is a power of two, so the prescaler wraps on overflow.
    presc_d   = presc_q + PW'(1);
    idx_d     = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IW'(1);
    snap_d    = frame_end ? value : snap_q;
  end

`ifdef SEVEN_SEG_DP_EN
  always_comb begin
    dp_snap_d = frame_end ? dp_in : dp_snap_q;
  end
`endif

  // Display decode for the current counter state; registered below.
  always_comb begin
    nibble = snap_q[4*int'(idx_q) +: 4];

    // lz[i] = nibble i and every higher nibble are zero.
    run_zero = 1'b1;
    lz       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (snap_q[4*i +: 4] == 4'h0);
      lz[i]    = run_zero;
    end
    lz[0] = 1'b0;

    blanked = blank_lz && lz[idx_q];
    phase   = presc_q[PW-1 -: BRIGHT_W];

    an_d = '0;
    if ((phase < brightness) && !blanked) an_d = DIGITS'(1) << idx_q;

    seg_d        = hex_to_seg(nibble);
`ifdef SEVEN_SEG_DP_EN
    dp_d         = dp_snap_q[idx_q];
`else
    dp_d         = 1'b0;
`endif
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

`ifdef SEVEN_SEG_DP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dp_snap_q <= '0;
    else        dp_snap_q <= dp_snap_d;
  end
`endif

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
module tb_seven_seg_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 64;
  localparam int BRIGHT_W = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  brightness = 4'h0;
  logic [3:0]  dp_in = 4'b0100;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  seven_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BRIGHT_W(BRIGHT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .blank_lz   (blank_lz),
    .brightness (brightness),
`ifdef SEVEN_SEG_DP_EN
    .dp_in      (dp_in),
`endif
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: k = clock edges since reset release.
  int          k = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dpsnap = 4'h0;
  logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    int t, presc, idx, phase;
    logic [15:0] upper;
    logic blank;
    logic [3:0] exp_an;
    logic exp_dp;
    @(posedge clk);
    #1;
    k++;
    t     = k - 1;
    presc = t % SCAN_DIV;
    idx   = (t / SCAN_DIV) % DIGITS;
    phase = presc / (SCAN_DIV >> BRIGHT_W);
    upper = m_snap >> (4 * idx);
    blank = blank_lz && (idx > 0) && (upper == 16'h0);
    exp_an = ((phase < int'(brightness)) && !blank) ? 4'(1 << idx) : 4'h0;
`ifdef SEVEN_SEG_DP_EN
    exp_dp = m_dpsnap[idx];
`else
    exp_dp = 1'b0;
`endif
    chk("an", 32'(an), 32'(exp_an));
    chk("seg", 32'(seg), 32'(seg_tab[upper[3:0]]));
    chk("dp", 32'(dp), 32'(exp_dp));
    chk("frame_tick", 32'(frame_tick), 32'((k % FRAME) == 0));
    if ((k % FRAME) == 0) begin
      m_snap   = value;
      m_dpsnap = dp_in;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"}, 32'(an), 32'h0);
    chk({tag, "_seg"}, 32'(seg), 32'h0);
    chk({tag, "_dp"}, 32'(dp), 32'h0);
    chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset    = 1'b1;
    k        = 0;
    m_snap   = 16'h0;
    m_dpsnap = 4'h0;
  endtask

  initial begin
    logic [15:0] masks [4] = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0000};

    // Reset state, then first frame shows the zero snapshot.
    value      = 16'h12AF;
    brightness = 4'd15;
    blank_lz   = 1'b0;
    #12;
    chk_reset_outputs("reset_init");
    release_reset();
    run(FRAME);
    run(10);
    chk("frame2_digit0_seg", 32'(seg), 32'h71);
    chk("frame2_digit0_an", 32'(an), 32'h1);
    run(FRAME - 10);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    value    = 16'h0070;
    run(2 * FRAME);
    value    = 16'h0000;
    run(2 * FRAME);

    // Brightness sweep.
    blank_lz   = 1'b0;
    value      = 16'h8C3E;
    brightness = 4'd0;
    run(2 * FRAME);
    brightness = 4'd8;
    run(FRAME);

    // Tear-free update: change value during digit 1's slot.
    brightness = 4'd15;
    value      = 16'h1111;
    run(FRAME);
    run(SCAN_DIV + 20);
    value = 16'h2222;
    run(FRAME - SCAN_DIV - 20);
    run(FRAME);

    // Asynchronous reset during digit 2's slot.
    run(2 * SCAN_DIV + 10);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    chk_reset_outputs("reset_held");
    release_reset();
    run(FRAME + 40);

    // Randomized inputs, including mid-frame changes.
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        if ($urandom_range(0, 99) < 2) value = 16'($urandom) & masks[$urandom_range(0, 3)];
        if ($urandom_range(0, 199) < 1) blank_lz = 1'($urandom);
        if ($urandom_range(0, 299) < 1) brightness = 4'($urandom);
        if ($urandom_range(0, 99) < 1) dp_in = 4'($urandom);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
